// File: rtl/gshare_predictor.sv
// Gshare branch predictor for the fetch stage.
// The PHT is indexed by the fetch address XOR the speculative global history,
// which sits in the top bits of the index. A committed (architectural) history
// is kept alongside so that a misprediction can rebuild the speculative one.
// After reset the PHT is swept to weakly-not-taken, one entry per cycle.
// A small circular return-address stack serves call/return prediction.
module gshare_predictor #(
  parameter int ADDR_WIDTH    = 14,
  parameter int PATTERN_WIDTH = 10,
  parameter int GH_WIDTH      = 4,
  parameter int CTR_WIDTH     = 2,
  parameter int RAS_DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     init_done,
  input  logic                     lookup_valid,
  input  logic [ADDR_WIDTH-1:0]    lookup_addr,
  output logic                     pred_taken,
  output logic [CTR_WIDTH-1:0]     pred_counter,
  output logic [PATTERN_WIDTH-1:0] pred_pattern,
  input  logic                     spec_valid,
  input  logic                     spec_taken,
  input  logic                     commit_valid,
  input  logic [PATTERN_WIDTH-1:0] commit_pattern,
  input  logic [CTR_WIDTH-1:0]     commit_counter,
  input  logic                     commit_taken,
  input  logic                     commit_mispredict,
  input  logic                     ras_push,
  input  logic [ADDR_WIDTH-1:0]    ras_push_addr,
  input  logic                     ras_pop,
  output logic [ADDR_WIDTH-1:0]    ras_top,
  output logic                     ras_empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CTR_WIDTH-1:0] WNT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t                   state, state_nxt;
  logic [PATTERN_WIDTH-1:0] idx, idx_nxt;
  logic [CTR_WIDTH-1:0]     pht [2**PATTERN_WIDTH];

  logic [GH_WIDTH-1:0]      spec_gh, arch_gh;
  logic [PATTERN_WIDTH-1:0] gh_ext, lookup_idx;
  logic [CTR_WIDTH-1:0]     train_ctr;

  logic [ADDR_WIDTH-1:0]    ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]         ras_ptr;
  logic [CNT_W-1:0]         ras_cnt;
  logic                     ras_nonempty, do_push, do_repl, do_pop;

  // Upper address bits do not take part in the index.
  logic addr_hi_unused;
  assign addr_hi_unused = ^lookup_addr;

  // History occupies the top of the index; the low bits come from the address alone.
  assign gh_ext     = PATTERN_WIDTH'(spec_gh) << (PATTERN_WIDTH - GH_WIDTH);
  assign lookup_idx = lookup_addr[PATTERN_WIDTH-1:0] ^ gh_ext;
  assign pred_taken = pred_counter[CTR_WIDTH-1];

  // Init sweep state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      idx       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      init_done <= (state == READY);
    end
  end

  // Init sweep next state: walk every index once, then settle in READY.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      INIT: begin
        idx_nxt = idx + 1'b1;
        if (&idx) state_nxt = READY;
      end
      default: ;
    endcase
  end

  // Saturating counter update for a retiring branch.
  always_comb begin
    if (commit_taken)
      train_ctr = (&commit_counter) ? commit_counter : commit_counter + 1'b1;
    else
      train_ctr = (commit_counter == '0) ? commit_counter : commit_counter - 1'b1;
  end

  // PHT write port: sweep owns it during INIT, training afterwards.
  always_ff @(posedge clk) begin
    if (state == INIT)
      pht[idx] <= WNT;
    else if (commit_valid)
      pht[commit_pattern] <= train_ctr;
  end

  // Prediction register; the PHT read sees the pre-write value on a collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pred_pattern <= '0;
      pred_counter <= WNT;
    end else if (lookup_valid) begin
      pred_pattern <= lookup_idx;
      pred_counter <= (state == INIT) ? WNT : pht[lookup_idx];
    end
  end

  // Global histories; a mispredict rebuilds the speculative one from the committed one.
  // Taking the low GH_WIDTH bits of {gh, bit} gives a shift that also covers GH_WIDTH=1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spec_gh <= '0;
      arch_gh <= '0;
    end else begin
      if (commit_valid)
        arch_gh <= GH_WIDTH'({arch_gh, commit_taken});
      if (commit_valid && commit_mispredict)
        spec_gh <= GH_WIDTH'({arch_gh, commit_taken});
      else if (spec_valid)
        spec_gh <= GH_WIDTH'({spec_gh, spec_taken});
    end
  end

  // RAS operation decode; push+pop on a non-empty stack replaces the top.
  always_comb begin
    ras_nonempty = (ras_cnt != '0);
    do_repl      = ras_push && ras_pop && ras_nonempty;
    do_push      = ras_push && !do_repl;
    do_pop       = ras_pop && !ras_push && ras_nonempty;
  end

  // RAS pointer and occupancy; a full stack keeps wrapping over its oldest entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (do_push) begin
      ras_ptr <= ras_ptr + 1'b1;
      if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
    end else if (do_pop) begin
      ras_ptr <= ras_ptr - 1'b1;
      ras_cnt <= ras_cnt - 1'b1;
    end
  end

  // RAS storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (do_repl)
      ras_mem[ras_ptr] <= ras_push_addr;
    else if (do_push)
      ras_mem[ras_ptr + 1'b1] <= ras_push_addr;
  end

  assign ras_empty = !ras_nonempty;
  assign ras_top   = ras_nonempty ? ras_mem[ras_ptr] : '0;

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised next-generation branch predictor for the fetch stage.
- Gshare PHT with configurable index, history and counter widths.
- Keeps separate speculative and committed global history, with recovery on misprediction.
- Adds a hardware PHT initialisation sweep after reset and a circular return-address stack (RAS). Fetch drives lookups and RAS operations; commit drives training.

Parameters:
ADDR_WIDTH, 14, instruction address width
PATTERN_WIDTH, 10, PHT index width; PHT depth is 2**PATTERN_WIDTH
GH_WIDTH, 4, global history length; must satisfy 1 <= GH_WIDTH <= PATTERN_WIDTH
CTR_WIDTH, 2, saturating counter width, >= 1
RAS_DEPTH, 8, return stack entries, power of two >= 2

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
init_done  out  1  high once the PHT sweep has completed
lookup_valid  in  1  fetch requests a prediction this cycle
lookup_addr  in  ADDR_WIDTH  address of the fetched instruction
pred_taken  out  1  MSB of pred_counter
pred_counter  out  CTR_WIDTH  counter value read for the last accepted lookup
pred_pattern  out  PATTERN_WIDTH  PHT index used; carried down the pipe to commit
spec_valid  in  1  fetch predicted a conditional branch; shift the speculative history
spec_taken  in  1  predicted direction shifted into the speculative history
commit_valid  in  1  a conditional branch retires
commit_pattern  in  PATTERN_WIDTH  index returned from pred_pattern
commit_counter  in  CTR_WIDTH  counter value returned from pred_counter
commit_taken  in  1  actual outcome
commit_mispredict  in  1  branch was mispredicted; recover the speculative history
ras_push  in  1  call fetched
ras_push_addr  in  ADDR_WIDTH  return address to push
ras_pop  in  1  return fetched
ras_top  out  ADDR_WIDTH  current top entry, combinational
ras_empty  out  1  stack holds no entries

Behaviour:
- Reset (async, reset_n low):
  - spec_gh = arch_gh = 0.
  - pred_taken = 0; pred_counter = WNT, where WNT = 2**(CTR_WIDTH-1)-1; pred_pattern = 0.
  - init_done = 0; sweep index = 0.
  - RAS pointer = 0, count = 0, ras_empty = 1.
  - PHT contents are not reset by reset_n.
- Init FSM, states INIT then READY:
  - INIT writes WNT to PHT[idx] and increments idx by one per cycle.
  - After writing the last entry (index 2**PATTERN_WIDTH-1), the FSM enters READY and raises init_done on the following edge.
  - Sweep takes 2**PATTERN_WIDTH cycles after reset release.
  - Assertion of reset_n low mid-sweep restarts the sweep at index 0.
- Lookup, 1-cycle latency:
  - Index p = lookup_addr[PATTERN_WIDTH-1:0] XOR {spec_gh, (PATTERN_WIDTH-GH_WIDTH) zeros}, using the spec_gh value before any update in the same cycle.
  - On lookup_valid: pred_pattern <= p; pred_counter <= PHT[p], or WNT while in INIT.
  - Without lookup_valid, outputs hold.
  - Read-before-write: a same-cycle commit to the same index returns the old value.
- Training, on commit_valid:
  - new = commit_counter+1 if commit_taken, else commit_counter-1, saturating at 2**CTR_WIDTH-1 and 0.
  - PHT[commit_pattern] <= new. Suppressed in INIT.
  - arch_gh <= {arch_gh[GH_WIDTH-2:0], commit_taken}. Always applied, including in INIT.
- Speculative history:
  - On spec_valid: spec_gh <= {spec_gh[GH_WIDTH-2:0], spec_taken}.
  - On commit_valid && commit_mispredict: spec_gh <= {arch_gh[GH_WIDTH-2:0], commit_taken}. This takes priority over spec_valid in the same cycle.
  - commit_mispredict without commit_valid is ignored.
- GH_WIDTH=1: shifting means replacing the single bit.
- RAS, circular:
  - Push: ptr <= ptr+1 mod RAS_DEPTH; entry[ptr+1] <= ras_push_addr; count saturates at RAS_DEPTH. When full, the oldest entry is overwritten silently.
  - Pop with count>0: ptr <= ptr-1; count-1.
  - Pop with count==0: no state change.
  - Push and pop in the same cycle: entry[ptr] <= ras_push_addr; ptr and count unchanged. If count==0, behaves as a push.
  - ras_top = entry[ptr]; it is 0 when count==0.
  - RAS is not repaired on misprediction.

Test Plan:
- Release reset_n, no stimulus -> init_done low for exactly 1024 cycles, high from cycle 1025; a lookup issued during INIT returns pred_counter=1, pred_taken=0.
- After init, spec_gh=0, lookup addr 0x005 -> next cycle pred_pattern=0x005, pred_counter=1; commit taken at 0x005 with counter 1, then commit taken with counter 2, then commit taken with counter 3 -> lookup returns 3, stays saturated at 3, pred_taken=1.
- spec_valid with taken=1,0,1 -> lookup addr 0x000 gives pred_pattern=0x140 (spec_gh=4'b0101); then commit_valid+mispredict with taken=1 and arch_gh=0 -> spec_gh=4'b0001, next lookup at 0 gives 0x040.
- Same cycle: spec_valid plus commit mispredict -> mispredict value wins. Same cycle: commit and lookup to the same index -> old counter returned, new value visible on the next lookup.
- Push 0x100..0x108 (9 pushes) -> ras_top=0x108; 8 pops return 0x108 down to 0x101, then ras_empty=1 and ras_top=0; extra pop changes nothing; push+pop on a non-empty stack replaces the top.
- Pulse reset_n low at sweep index 500 -> sweep restarts; init_done rises 1024 cycles after release; RAS and both histories are zero.
